// File: rtl/passcode_input_capture_if.sv
// Operand/opcode capture bus: raw switch and button inputs, captured outputs and status.
interface passcode_input_capture_if;
   logic [9:0] sw_a;
   logic [9:0] sw_b;
   logic [2:0] sw_op;
   logic       btn_enter;
   logic [9:0] a;
   logic [9:0] b;
   logic [2:0] op;
   logic       valid;
   logic       err;
   logic       busy;
   logic [7:0] entry_cnt;

   modport master (
      output sw_a, sw_b, sw_op, btn_enter,
      input  a, b, op, valid, err, busy, entry_cnt
   );

   modport slave (
      input  sw_a, sw_b, sw_op, btn_enter,
      output a, b, op, valid, err, busy, entry_cnt
   );
endinterface

// File: rtl/passcode_input_capture.sv
// Synchronises switches and enter button, debounces presses, latches one a/b/op set per press.
// Optional macro PASSCODER_STABLE_CHECK_EN rejects captures whose switches moved during debounce.
module passcode_input_capture #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic                      clk,
   input  logic                      rst,
   passcode_input_capture_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_CAPTURE  = 2'd2,
      S_RELEASE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic             r_btn_p0;
   logic             r_btn_p1;
   logic [22:0]      r_sw_p0;
   logic [22:0]      r_sw_p1;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [9:0]       r_a;
   logic [9:0]       r_b;
   logic [2:0]       r_op;
   logic             r_valid;
   logic [7:0]       r_entry_cnt;
   logic             w_btn_s;
   logic [22:0]      w_sw_s;
   logic [22:0]      w_sw_raw;
   logic             w_capture;
   logic             w_snap_load;
   logic             w_sw_match;
   logic             w_load;

   assign w_sw_raw = {bus.sw_a, bus.sw_b, bus.sw_op};
   assign w_btn_s  = r_btn_p1;
   assign w_sw_s   = r_sw_p1;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      w_snap_load = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_btn_s) begin
               w_state_nxt = S_DEBOUNCE;
               w_cnt_nxt   = CNT_W'(1);
               w_snap_load = 1'b1;
            end else begin
               w_cnt_nxt   = '0;
            end
         end
         S_DEBOUNCE: begin
            if (!w_btn_s) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == LP_CNT_MAX) begin
               // Outputs register on this edge so a/b/op appear together with valid.
               w_state_nxt = S_CAPTURE;
               w_capture   = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         S_CAPTURE: begin
            w_state_nxt = S_RELEASE;
            w_cnt_nxt   = '0;
         end
         S_RELEASE: begin
            if (w_btn_s) begin
               w_cnt_nxt   = '0;
            end else if (r_cnt == LP_CNT_MAX) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

`ifdef PASSCODER_STABLE_CHECK_EN
   logic [22:0] r_snap;
   logic        r_err;
   logic        w_reject;

   assign w_sw_match = (w_sw_s == r_snap);
   assign w_reject   = w_capture & ~w_sw_match;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_snap <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_snap_load) r_snap <= w_sw_s;
         r_err <= w_reject;
      end
   end

   assign bus.err = r_err;
`else
   assign w_sw_match = 1'b1;
   assign bus.err    = 1'b0;
`endif

   assign w_load = w_capture & w_sw_match;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_btn_p0    <= 1'b0;
         r_btn_p1    <= 1'b0;
         r_sw_p0     <= '0;
         r_sw_p1     <= '0;
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= '0;
         r_valid     <= 1'b0;
         r_entry_cnt <= '0;
      end else begin
         r_btn_p0 <= bus.btn_enter;
         r_btn_p1 <= r_btn_p0;
         r_sw_p0  <= w_sw_raw;
         r_sw_p1  <= r_sw_p0;
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_valid  <= w_load;
         if (w_load) begin
            r_a         <= w_sw_s[22:13];
            r_b         <= w_sw_s[12:3];
            r_op        <= w_sw_s[2:0];
            r_entry_cnt <= r_entry_cnt + 8'd1;
         end
      end
   end

   assign bus.a         = r_a;
   assign bus.b         = r_b;
   assign bus.op        = r_op;
   assign bus.valid     = r_valid;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.entry_cnt = r_entry_cnt;

   // Keeps the unused-in-default-build snapshot strobe from being flagged.
   logic w_unused;
   assign w_unused = w_snap_load;

endmodule

// File: tb/tb_passcode_input_capture.sv
// Randomised bench for passcode_input_capture: run-length reference model plus directed literal checks.
module tb_passcode_input_capture;

   localparam int D = 4;

   logic clk;
   logic rst;
   passcode_input_capture_if tif ();

   passcode_input_capture #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (tif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int n_valid  = 0;
   int n_errp   = 0;

   // Reference model: the button seen by the logic is the raw button two edges late;
   // a capture needs D+1 consecutive high samples, re-arming needs D+1 consecutive lows
   // counted from the second edge after the capture.
   logic        hist_btn [2];
   logic [22:0] hist_sw  [2];
   int          m_mode;   // 0 waiting for press, 1 capture cycle, 2 waiting for release
   int          m_run;
   logic [22:0] m_snap;
   logic [9:0]  m_a, m_b;
   logic [2:0]  m_op;
   logic        m_valid, m_err, m_busy;
   logic [7:0]  m_cnt;
   logic        m_live = 1'b0;
   logic        mb;
   logic [22:0] ms;
   logic        m_ok;

   always @(posedge clk) begin
      if (rst) begin
         hist_btn[0] = 0; hist_btn[1] = 0; hist_sw[0] = 0; hist_sw[1] = 0;
         m_mode = 0; m_run = 0; m_snap = 0;
         m_a = 0; m_b = 0; m_op = 0; m_valid = 0; m_err = 0; m_busy = 0; m_cnt = 0;
         m_live = 1'b1;
      end else if (m_live) begin
         mb = hist_btn[1];
         ms = hist_sw[1];
         m_valid = 0;
         m_err   = 0;
         if (m_mode == 0) begin
            if (mb) begin
               m_run = m_run + 1;
               if (m_run == 1) m_snap = ms;
               if (m_run == D + 1) begin
`ifdef PASSCODER_STABLE_CHECK_EN
                  m_ok = (ms == m_snap);
`else
                  m_ok = 1'b1;
`endif
                  if (m_ok) begin
                     m_a = ms[22:13]; m_b = ms[12:3]; m_op = ms[2:0];
                     m_valid = 1; m_cnt = m_cnt + 8'd1;
                  end else begin
                     m_err = 1;
                  end
                  m_mode = 1; m_run = 0;
               end
            end else begin
               m_run = 0;
            end
         end else if (m_mode == 1) begin
            m_mode = 2; m_run = 0;
         end else begin
            if (mb) m_run = 0;
            else m_run = m_run + 1;
            if (m_run == D + 1) begin
               m_mode = 0; m_run = 0;
            end
         end
         m_busy = (m_mode != 0) || (m_run > 0);
         hist_btn[1] = hist_btn[0];
         hist_sw[1]  = hist_sw[0];
         hist_btn[0] = tif.btn_enter;
         hist_sw[0]  = {tif.sw_a, tif.sw_b, tif.sw_op};
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         n_checks++;
         if ({tif.a, tif.b, tif.op, tif.valid, tif.err, tif.busy, tif.entry_cnt} !==
             {m_a, m_b, m_op, m_valid, m_err, m_busy, m_cnt}) begin
            n_err++;
            $display("FAIL cycle_cmp t=%0t got a=%h b=%h op=%0d valid=%b err=%b busy=%b cnt=%0d expected a=%h b=%h op=%0d valid=%b err=%b busy=%b cnt=%0d",
                     $time, tif.a, tif.b, tif.op, tif.valid, tif.err, tif.busy, tif.entry_cnt,
                     m_a, m_b, m_op, m_valid, m_err, m_busy, m_cnt);
         end
         if (tif.valid === 1'b1) n_valid++;
         if (tif.err === 1'b1) n_errp++;
      end
   end

   task automatic check_lit(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic set_sw(input logic [9:0] sa, input logic [9:0] sb, input logic [2:0] so);
      tif.sw_a = sa; tif.sw_b = sb; tif.sw_op = so;
   endtask

   task automatic press(input int hold, input int gap);
      tif.btn_enter = 1'b1;
      repeat (hold) @(negedge clk);
      tif.btn_enter = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   int seg;
   int vbase;

   initial begin
      rst = 1'b1;
      tif.btn_enter = 1'b0;
      set_sw(10'h0, 10'h0, 3'h0);
      repeat (3) @(negedge clk);
      check_lit("reset_a",   int'(tif.a), 0);
      check_lit("reset_b",   int'(tif.b), 0);
      check_lit("reset_op",  int'(tif.op), 0);
      check_lit("reset_flags", int'({tif.valid, tif.err, tif.busy}), 0);
      check_lit("reset_cnt", int'(tif.entry_cnt), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Reset during debounce discards the press.
      set_sw(10'h111, 10'h222, 3'd3);
      repeat (3) @(negedge clk);
      tif.btn_enter = 1'b1;
      repeat (4) @(negedge clk);
      check_lit("debounce_busy", int'(tif.busy), 1);
      rst = 1'b1;
      tif.btn_enter = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_lit("rst_mid_busy", int'(tif.busy), 0);
      check_lit("rst_mid_a", int'(tif.a), 0);
      repeat (20) @(negedge clk);
      check_lit("rst_mid_no_valid", n_valid, 0);

      // Clean press: valid the cycle after edge N+2+D.
      set_sw(10'h2A5, 10'h0F3, 3'd5);
      repeat (4) @(negedge clk);
      tif.btn_enter = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check_lit("latency_early_valid", int'(tif.valid), 0);
      @(posedge clk);
      #1;
      check_lit("latency_valid", int'(tif.valid), 1);
      check_lit("latency_a", int'(tif.a), 'h2A5);
      check_lit("latency_b", int'(tif.b), 'h0F3);
      check_lit("latency_op", int'(tif.op), 5);
      check_lit("latency_cnt", int'(tif.entry_cnt), 1);
      @(negedge clk);
      tif.btn_enter = 1'b0;
      repeat (20) @(negedge clk);

      // Bounce never reaches the threshold.
      press(3, 1);
      press(3, 15);
      check_lit("bounce_busy", int'(tif.busy), 0);
      check_lit("bounce_cnt", int'(tif.entry_cnt), 1);
      check_lit("bounce_a", int'(tif.a), 'h2A5);

      // Long hold with switch movement: one capture of the original switches.
      set_sw(10'h1C3, 10'h2F0, 3'd2);
      repeat (3) @(negedge clk);
      tif.btn_enter = 1'b1;
      repeat (20) @(negedge clk);
      set_sw(10'h055, 10'h3AA, 3'd6);
      repeat (30) @(negedge clk);
      tif.btn_enter = 1'b0;
      repeat (20) @(negedge clk);
      check_lit("hold_cnt", int'(tif.entry_cnt), 2);
      check_lit("hold_a", int'(tif.a), 'h1C3);
      check_lit("hold_b", int'(tif.b), 'h2F0);
      check_lit("hold_op", int'(tif.op), 2);
      press(8, 15);
      check_lit("second_cnt", int'(tif.entry_cnt), 3);
      check_lit("second_a", int'(tif.a), 'h055);
      check_lit("second_b", int'(tif.b), 'h3AA);

`ifdef PASSCODER_STABLE_CHECK_EN
      // Switch change mid-debounce is rejected.
      set_sw(10'h300, 10'h0AB, 3'd1);
      repeat (3) @(negedge clk);
      tif.btn_enter = 1'b1;
      repeat (3) @(negedge clk);
      tif.sw_b = 10'h0AC;
      repeat (10) @(negedge clk);
      tif.btn_enter = 1'b0;
      repeat (15) @(negedge clk);
      check_lit("stable_errp", n_errp, 1);
      check_lit("stable_cnt", int'(tif.entry_cnt), 3);
      check_lit("stable_a", int'(tif.a), 'h055);
`endif

      // 256 presses wrap the counter back to 0.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vbase = n_valid;
      for (int i = 0; i < 256; i++) begin
         set_sw(10'($urandom), 10'($urandom), 3'($urandom));
         repeat (3) @(negedge clk);
         press(6, 10);
      end
      check_lit("wrap_cnt", int'(tif.entry_cnt), 0);
      check_lit("wrap_valids", n_valid - vbase, 256);

      // Random bursts, switch motion and occasional reset.
      for (int i = 0; i < 400; i++) begin
         tif.btn_enter = 1'($urandom_range(0, 1));
         seg = (($urandom_range(0, 3) == 0) ? $urandom_range(5, 14) : $urandom_range(1, 6));
         for (int k = 0; k < seg; k++) begin
            if ($urandom_range(0, 7) == 0) set_sw(10'($urandom), 10'($urandom), 3'($urandom));
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
         end
      end
      rst = 1'b0;
      tif.btn_enter = 1'b0;
      repeat (20) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
